bus_mem_slave: RTL
==================

# bus_mem_slave

Memory-side responder for the shared CPU/memory bus (req/start/gnt/rdy/mode/addr/data signal set). It sits directly downstream of the CPU core. It arbitrates a single requester with a grant handshake, captures one command per `start`, and inserts a programmable number of wait states. It then executes read, write, increment or clear on an internal 2**ADDR_W x DATA_W array and signals completion with a one-cycle `rdy` pulse.

## Interface
- `ADDR_W`, 8, address width; array depth is 2**ADDR_W
- `DATA_W`, 8, data width
- `WAIT_STATES`, 1, extra access cycles between capture and completion (0..15)

Ports:
- `clk`  in  1  bus clock; single clock domain, all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `req`  in  1  requester wants the bus
- `start`  in  1  command strobe, valid only while `gnt`=1 in GRANT
- `mode`  in  2  command: 00 read, 01 write, 10 increment, 11 clear
- `addr`  in  ADDR_W  target address, sampled with `start`
- `wdata`  in  DATA_W  write data, sampled with `start` (mode 01 only)
- `gnt`  out  1  bus granted
- `rdy`  out  1  one-cycle completion pulse
- `rdata`  out  DATA_W  pre-operation contents of the addressed word, valid while `rdy`=1

## Operation
- States: IDLE, GRANT, BUSY, DONE.
- Reset values: state IDLE, `gnt`=0, `rdy`=0, `rdata`=0, wait counter 0. The array is not reset; contents are X until written.
- IDLE:
  - `req`=1 → GRANT.
  - `start` is ignored.
- GRANT (`gnt`=1):
  - `start`=1 → capture `mode`/`addr`/`wdata`, load counter with WAIT_STATES, go to BUSY.
  - `req`=0 and `start`=0 → IDLE.
  - `start` takes priority over `req`=0 in the same cycle.
- BUSY (`gnt`=1):
  - Counter nonzero → decrement.
  - Counter zero → execute the captured command, go to DONE.
  - `start`, `mode`, `addr` and `wdata` are ignored in BUSY.
- Execute, all modes: `rdata` ← mem[a] (old value).
  - write: mem[a] ← wdata.
  - increment: mem[a] ← mem[a]+1 modulo 2**DATA_W, so 0xFF wraps to 0x00.
  - clear: mem[a] ← 0.
  - read: array unchanged.
- DONE:
  - `rdy`=1, `gnt`=1.
  - Next edge: `req`=1 → GRANT (back-to-back, no IDLE gap); otherwise → IDLE.
  - `rdata` holds its value until the next execute or reset.
- Reset mid-operation: on the reset edge the state returns to IDLE. No array write occurs on that edge, even if the counter was zero.

## Timing
- `req` high before edge n → `gnt`=1 from edge n.
- `start` sampled at edge k → `rdy`=1 for exactly the cycle after edge k+WAIT_STATES+1. Latency is WAIT_STATES+1 cycles.
- The array write and `rdata` update happen on the same edge that raises `rdy`.
- Back-to-back with `req` held high: DONE → GRANT, so the next `start` can be sampled one edge after the `rdy` cycle. Minimum period is WAIT_STATES+3 cycles per command.
- `gnt` falls on the edge leaving GRANT or DONE to IDLE.
- `rdy` is never high for two consecutive cycles.

## Test plan
- Reset, then `req`=1 → `gnt`=0 during reset, `gnt`=1 one edge after the first non-reset sample of `req`; `rdy`=0 throughout.
- WAIT_STATES=1: write 0x5A to 0x10, then read 0x10 → each `rdy` arrives 2 cycles after `start`; the read returns `rdata`=0x5A.
- Increment 0x20 holding 0xFF → `rdata`=0xFF; a following read returns 0x00 (wrap). Clear 0x10 → `rdata`=0x5A; a following read returns 0x00.
- Three commands back-to-back with `req` held high → `gnt` stays 1 and never dips; three single-cycle `rdy` pulses 4 cycles apart.
- `start` pulsed in IDLE (`req`=0), and again mid-BUSY with different `addr`/`wdata` → both ignored; only the originally captured command executes.
- Write 0x33 to 0x40 with WAIT_STATES=3, assert `rst` in the second BUSY cycle → state IDLE, no `rdy`; after 0x40 is written with 0x11, a read of 0x40 returns 0x11, not 0x33.

Source files
------------

// File: rtl/bus_mem_slave.sv
// Memory-side bus responder: grant handshake, one command per start,
// programmable wait states, read/write/increment/clear on an internal array.
module bus_mem_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_BUSY,
    S_DONE
  } state_e;

  localparam logic [1:0] M_READ  = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_INC   = 2'b10;
  localparam logic [1:0] M_CLR   = 2'b11;
  localparam logic [3:0] WS_L    = 4'(WAIT_STATES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [2**ADDR_W];
  logic [DATA_W-1:0]   mem_old;
  logic [DATA_W-1:0]   mem_wd;
  logic                exec;
  logic                mem_we;

  assign mem_old = mem[addr_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    exec    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req) state_d = S_GRANT;
      end
      S_GRANT: begin
        if (start) begin
          mode_d  = mode;
          addr_d  = addr;
          wdata_d = wdata;
          cnt_d   = WS_L;
          state_d = S_BUSY;
        end else if (!req) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          exec    = 1'b1;
          rdata_d = mem_old;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = req ? S_GRANT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_we = exec;
    mem_wd = mem_old;
    unique case (mode_q)
      M_READ:  mem_we = 1'b0;
      M_WRITE: mem_wd = wdata_q;
      M_INC:   mem_wd = mem_old + DATA_W'(1);
      M_CLR:   mem_wd = '0;
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Array has no reset; a reset edge must still suppress a pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[addr_q] <= mem_wd;
  end

  assign gnt   = (state_q != S_IDLE);
  assign rdy   = (state_q == S_DONE);
  assign rdata = rdata_q;

endmodule
